// File: rtl/ir_fetch_pkg.sv
// Shared encodings for the instruction-register / interrupt-injection stage.
// Interrupt sources, vector addresses and the forced BRK opcode.
package ir_fetch_pkg;

    // RESET needs a fifth code, so the source field is 3 bits wide
    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,
        SRC_BRK   = 3'd1,
        SRC_IRQ   = 3'd2,
        SRC_NMI   = 3'd3,
        SRC_RESET = 3'd4
    } int_src_t;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    localparam logic [7:0] OP_BRK = 8'h00;

    function automatic logic [15:0] src_vector(int_src_t s);
        logic [15:0] v;
        v = VEC_IRQ;
        if (s == SRC_RESET) v = VEC_RST;
        if (s == SRC_NMI)   v = VEC_NMI;
        return v;
    endfunction

endpackage

// File: rtl/ir_fetch_if.sv
// Sequencer <-> fetch-stage bundle: fetch qualifiers in, opcode and
// interrupt qualifiers out.
interface ir_fetch_if;
    import ir_fetch_pkg::*;

    logic       rdy;
    logic       sync;
    logic [7:0] data_in;
    logic       i_flag;
    logic       nmi_n;
    logic       irq_n;
    logic       vec_ack;

    logic [7:0]  opcode;
    int_src_t    int_src;
    logic [15:0] vector;
    logic        b_flag;
    logic        stack_wr_inhibit;
    logic        pc_inc_inhibit;

    modport master (
        output rdy, sync, data_in, i_flag,
        output nmi_n, irq_n, vec_ack,
        input  opcode, int_src, vector,
        input  b_flag, stack_wr_inhibit, pc_inc_inhibit
    );

    modport slave (
        input  rdy, sync, data_in, i_flag,
        input  nmi_n, irq_n, vec_ack,
        output opcode, int_src, vector,
        output b_flag, stack_wr_inhibit, pc_inc_inhibit
    );

endinterface

// File: rtl/ir_fetch_nmi_edge.sv
// Synchroniser with falling-edge detect and a set-dominant pending latch.
// Sync flops run regardless of rdy; only the clear is qualified upstream.
module ir_fetch_nmi_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_n,
    input  logic clr,
    output logic level,
    output logic fall,
    output logic pend
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    assign level = sync_q[STAGES-1];
    assign fall  = last_q & ~sync_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            last_q <= 1'b1;
            pend   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_n};
            last_q <= sync_q[STAGES-1];
            if (fall)
                pend <= 1'b1;
            else if (clr)
                pend <= 1'b0;
        end
    end

endmodule

// File: rtl/ir_fetch.sv
// Instruction register with forced-BRK injection for RESET/NMI/IRQ,
// plus vector select and BRK-sequence qualifiers for the sequencer.
module ir_fetch
    import ir_fetch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input logic        clk_m2,
    input logic        rst_n,
    ir_fetch_if.slave  bus
);

    logic     nmi_lvl;
    logic     nmi_fall;
    logic     nmi_pend;
    logic     nmi_clr;
    logic     irq_s;
    logic     irq_fall;
    logic     irq_pend;
    logic     irq_lvl;
    logic     unused_sync;
    logic     rst_pend;
    logic     capture;
    logic     vec_take;
    logic     hijack;
    logic [7:0] opcode_q;
    logic [7:0] op_d;
    int_src_t src_q;
    int_src_t src_d;

    ir_fetch_nmi_edge #(.STAGES(SYNC_STAGES)) u_nmi (
        .clk     (clk_m2),
        .rst_n   (rst_n),
        .async_n (bus.nmi_n),
        .clr     (nmi_clr),
        .level   (nmi_lvl),
        .fall    (nmi_fall),
        .pend    (nmi_pend)
    );

    ir_fetch_nmi_edge #(.STAGES(SYNC_STAGES)) u_irq (
        .clk     (clk_m2),
        .rst_n   (rst_n),
        .async_n (bus.irq_n),
        .clr     (1'b0),
        .level   (irq_s),
        .fall    (irq_fall),
        .pend    (irq_pend)
    );

    assign unused_sync = nmi_lvl & irq_fall & irq_pend;
    assign irq_lvl     = ~irq_s;

    assign capture  = bus.sync & bus.rdy;
    assign vec_take = bus.vec_ack & bus.rdy;

    // A pending NMI steals the vector fetch of an IRQ/BRK sequence
    assign hijack  = vec_take & nmi_pend &
                     (src_q == SRC_IRQ || src_q == SRC_BRK);
    assign nmi_clr = vec_take &
                     (src_q == SRC_NMI || src_q == SRC_IRQ ||
                      src_q == SRC_BRK);

    always_comb begin
        op_d  = bus.data_in;
        src_d = (bus.data_in == OP_BRK) ? SRC_BRK : SRC_NONE;
        if (rst_pend) begin
            op_d  = OP_BRK;
            src_d = SRC_RESET;
        end else if (nmi_pend) begin
            op_d  = OP_BRK;
            src_d = SRC_NMI;
        end else if (irq_lvl && !bus.i_flag) begin
            op_d  = OP_BRK;
            src_d = SRC_IRQ;
        end
    end

    always_ff @(posedge clk_m2 or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= OP_BRK;
            src_q    <= SRC_RESET;
            rst_pend <= 1'b1;
        end else begin
            if (capture) begin
                opcode_q <= op_d;
                src_q    <= src_d;
            end
            if (vec_take && src_q == SRC_RESET)
                rst_pend <= 1'b0;
        end
    end

    assign bus.opcode  = opcode_q;
    assign bus.int_src = src_q;
    assign bus.vector  = hijack ? VEC_NMI : src_vector(src_q);
    assign bus.b_flag  = (src_q == SRC_BRK);
    assign bus.stack_wr_inhibit = (src_q == SRC_RESET);
    assign bus.pc_inc_inhibit   = (src_q == SRC_IRQ) ||
                                  (src_q == SRC_NMI) ||
                                  (src_q == SRC_RESET);

endmodule
